data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 68 ++++++
 tb/tb_data_mem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory behind an IDLE/BUSY/DONE handshake for the MEM stage.
module data_mem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        stall,
   output logic        done,
   output logic        addr_error
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
   state_t r_state, w_next;
   logic [2:0] r_cnt;
   logic r_write;
   logic [ADDR_BITS-1:0] r_idx;
   logic [31:0] r_wdata;
   logic [31:0] r_mem [2**ADDR_BITS];
   logic w_req, w_err, w_accept, w_commit;
   assign w_req = mem_read | mem_write;
   assign w_err = (addr[1:0] != 2'b00) | (addr[31:ADDR_BITS+2] != '0);
   assign w_accept = (r_state == IDLE) & w_req;
   assign w_commit = (r_state == BUSY) & (r_cnt == 3'd0);
   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   // Misaligned or out-of-range requests bypass BUSY and answer on the next edge.
   always_comb begin
      w_next = r_state == IDLE ? (w_req ? (w_err ? DONE : BUSY) : IDLE) :
               r_state == BUSY ? (r_cnt == 3'd0 ? DONE : BUSY) : IDLE;
   end
   always_comb begin
      stall = w_req & ~done & (r_state != DONE);
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= 3'd0;
         read_data <= 32'd0;
         done <= 1'b0;
         addr_error <= 1'b0;
         r_write <= 1'b0;
         r_idx <= '0;
         r_wdata <= 32'd0;
      end else begin
         done <= (w_next == DONE);
         addr_error <= w_accept & w_err;
         if (w_accept) begin
            r_write <= mem_write;
            r_idx <= addr[ADDR_BITS+1:2];
            r_wdata <= write_data;
            r_cnt <= CNT_INIT;
         end else if (r_state == BUSY && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
         if (w_accept && w_err) read_data <= 32'd0;
         else if (w_commit && !r_write) read_data <= r_mem[r_idx];
      end
   end
   // Memory has no reset; an access interrupted by reset never commits.
   always_ff @(posedge clk) begin
      if (reset && w_commit && r_write) r_mem[r_idx] <= r_wdata;
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder.
module tb_data_mem_responder;
   localparam int AB = 8;
   localparam int LAT = 2;
   logic clk = 1'b0, reset = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] addr = 32'd0, write_data = 32'd0;
   logic [31:0] read_data;
   logic stall, done, addr_error;
   int cyc = 0;
   int n_tests = 0, n_fail = 0;
   int done_cyc = -1, prev_done_cyc = -1;
   typedef struct {logic [31:0] rd; logic err; int start; int lat;} exp_t;
   exp_t q[$];
   logic [31:0] m_mem [int];
   logic [31:0] m_rd = 32'd0;

   data_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .write_data(write_data), .read_data(read_data),
      .stall(stall), .done(done), .addr_error(addr_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (reset === 1'b1 && done === 1'b1) begin
         prev_done_cyc = done_cyc;
         done_cyc = cyc;
         if (q.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
         else begin
            e = q.pop_front();
            chk("rdata", read_data, e.rd);
            chk("err", {31'd0, addr_error}, {31'd0, e.err});
            chk("lat", cyc - e.start, e.lat);
         end
      end
   end

   task automatic idle(input int n);
      mem_read = 1'b0;
      mem_write = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd, input int drop = 99);
      exp_t e;
      logic err;
      int k;
      err = (a[1:0] != 2'b00) || (a[31:AB+2] != 0);
      e.start = cyc;
      e.lat = err ? 1 : LAT + 1;
      e.err = err;
      if (err) m_rd = 32'd0;
      else if (wr) m_mem[int'(a[AB+1:2])] = wd;
      else m_rd = m_mem[int'(a[AB+1:2])];
      e.rd = m_rd;
      q.push_back(e);
      mem_read = rd;
      mem_write = wr;
      addr = a;
      write_data = wd;
      #1;
      k = 0;
      while (done !== 1'b1 && k <= 10) begin
         chk("stall", {31'd0, stall}, (k < drop) ? 32'd1 : 32'd0);
         if (k > 0) chk("err_low", {31'd0, addr_error}, 32'd0);
         @(posedge clk);
         #1;
         k++;
         if (k == drop) begin
            mem_read = 1'b0;
            mem_write = 1'b0;
         end
         #1;
      end
      if (done !== 1'b1) begin
         chk("timeout", {31'd0, done}, 32'd1);
         if (q.size() > 0) e = q.pop_back();
      end else chk("stall_done", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_read = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, addr_error}, 32'd0);
      chk("rst_stall_req", {31'd0, stall}, 32'd1);
      mem_read = 1'b0;
      #1;
      chk("rst_stall_idle", {31'd0, stall}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      idle(2);
      access(1'b1, 1'b0, 32'h10, 32'd0);
      idle(1);
      access(1'b1, 1'b0, 32'h13, 32'd0);
      idle(1);
      access(1'b1, 1'b0, 32'h400, 32'd0);
      idle(1);
      access(1'b0, 1'b1, 32'h11, 32'hBAD0BAD0);
      idle(1);
      access(1'b0, 1'b1, 32'h8000_0010, 32'hBAD1BAD1);
      idle(1);
      access(1'b1, 1'b0, 32'h10, 32'd0, 1);
      idle(2);
      access(1'b0, 1'b1, 32'h20, 32'hCAFE0001);
      idle(1);
      access(1'b1, 1'b0, 32'h20, 32'd0);
      idle(1);
      mem_write = 1'b1;
      addr = 32'h20;
      write_data = 32'h12345678;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("busy_no_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_busy_stall", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      chk("rst_busy_done", {31'd0, done}, 32'd0);
      chk("rst_busy_rdata", read_data, 32'd0);
      mem_write = 1'b0;
      reset = 1'b1;
      m_rd = 32'd0;
      idle(5);
      access(1'b1, 1'b0, 32'h20, 32'd0);
      idle(1);
      access(1'b0, 1'b1, 32'h20, 32'h1);
      access(1'b1, 1'b0, 32'h20, 32'd0);
      chk("b2b_gap", done_cyc - prev_done_cyc, 32'd4);
      idle(1);
      access(1'b1, 1'b1, 32'h24, 32'h55);
      idle(1);
      access(1'b1, 1'b0, 32'h24, 32'd0);
      idle(1);
      access(1'b1, 1'b0, 32'h10, 32'd0);
      idle(3);
      chk("sb_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
